i2c_line_cond: RTL and testbench
================================

// Module: i2c_line_cond
// PURPOSE
//   Input conditioner for the I2C slave: synchronises raw SCL/SDA pins to clk, rejects glitches,
//   and emits clean levels plus one-cycle SCL edge, START and STOP strobes and a bus-busy flag.
//   Sits directly upstream of i2c_fsm; its outputs are the only bus view the FSM uses.
// PARAMETERS
//   SYNC_STAGES  2   flops in each pin synchroniser (>=2)
//   FILT_LEN     4   consecutive cycles a synced level must hold before it is accepted (1..255)
// PORTS
//   clk        in   1  system clock, all logic on posedge
//   rst_n      in   1  asynchronous, active-low reset
//   scl_in     in   1  raw SCL pin (asynchronous)
//   sda_in     in   1  raw SDA pin (asynchronous)
//   scl        out  1  filtered SCL level
//   sda        out  1  filtered SDA level
//   scl_rise   out  1  1-cycle pulse: filtered SCL 0->1
//   scl_fall   out  1  1-cycle pulse: filtered SCL 1->0
//   start_det  out  1  1-cycle pulse: START or repeated START
//   stop_det   out  1  1-cycle pulse: STOP
//   bus_busy   out  1  high from START to STOP
//   glitch_cnt out  8  rejected-pulse count (only with I2C_COND_GLITCH_CNT_EN)
// BEHAVIOUR
//   Reset: sync flops, scl, sda = 1 (idle bus); all pulses, bus_busy, filter counters, glitch_cnt = 0.
//   Sync: SYNC_STAGES-flop chain per pin; no logic between stages.
//   Filter (per line): cnt counts cycles with synced != filtered; cnt==FILT_LEN-1 with mismatch ->
//     filtered toggles, cnt<=0. Synced==filtered -> cnt<=0. Latency pin->filtered = SYNC_STAGES+FILT_LEN.
//     FILT_LEN=1: filtered follows synced with 1 cycle delay.
//   Edges: scl_rise/scl_fall registered from filtered scl vs. its previous value; same cycle as
//     the filtered change is visible on scl.
//   START: filtered sda 1->0 while filtered scl is 1 and was 1 last cycle. STOP: sda 0->1, same qualifier.
//   SCL and SDA toggle in the same cycle: SCL edge reported, no START/STOP.
//   Bus FSM, states IDLE/BUSY: IDLE->BUSY on start_det; BUSY->IDLE on stop_det;
//     start_det in BUSY (repeated START) pulses, stays BUSY; stop_det in IDLE pulses, stays IDLE.
//   bus_busy = (state==BUSY), registered; rises the cycle after start_det.
//   rst_n asserted mid-transfer: all state returns to reset values immediately; after release
//     the first START is detected normally, no stale pulses.
//   Pulses never exceed one cycle; start_det and stop_det never coincide.
// CONFIGURATION
//   `I2C_COND_GLITCH_CNT_EN defined: glitch_cnt port exists; +1 whenever a line's cnt is nonzero
//     and synced returns to filtered before acceptance (SCL and SDA in same cycle: +2);
//     saturates at 8'hFF; cleared only by reset.
//   Not defined: port and counter logic absent; all other behaviour identical.
// STRUCTURE
//   Shared include i2c_defs.vh: bus state localparams (I2C_BUS_IDLE=1'b0, I2C_BUS_BUSY=1'b1),
//     default SYNC_STAGES/FILT_LEN values, shared with i2c_fsm.
//   Sub-module i2c_glitch_filter (sync chain + filter counter + glitch strobe), instantiated
//     once for SCL, once for SDA; edge/START/STOP/bus FSM live in the top.
// TESTING
//   1. Reset, pins held 1 -> scl=sda=1, all pulses 0, bus_busy=0, glitch_cnt=0.
//   2. FILT_LEN=4: SDA 1->0 with SCL=1, hold 10 cycles -> sda falls 6 cycles after the pin change,
//      start_det one cycle, bus_busy=1 next cycle; SDA 0->1 with SCL=1 -> stop_det, bus_busy=0.
//   3. 3-cycle low pulse on SCL (FILT_LEN=4) -> scl stays 1, no edges; glitch_cnt=1 (macro on).
//   4. START, 9 SCL clocks, SDA low with SCL high, SDA 1->0 with SCL high (repeated START) ->
//      9 scl_rise/9 scl_fall, second start_det, bus_busy held 1 throughout.
//   5. SCL and SDA fall on the same pin cycle -> scl_fall only, start_det=0.
//   6. rst_n low mid-byte while BUSY, release with bus idle -> bus_busy=0, no pulses;
//      next START gives start_det normally. 300 glitches -> glitch_cnt=8'hFF.

Source files
------------

// File: rtl/i2c_line_cond_pkg.sv
// Shared definitions for the I2C line conditioner and the downstream i2c_fsm.
// Contents:
//   bus_state_e      : bus-level state (I2C_BUS_IDLE / I2C_BUS_BUSY)
//   I2C_SYNC_STAGES  : default synchroniser depth
//   I2C_FILT_LEN     : default glitch-filter acceptance length
//   sat_add8()       : 8-bit saturating add of a small increment
package i2c_line_cond_pkg;

  typedef enum logic {
    I2C_BUS_IDLE = 1'b0,
    I2C_BUS_BUSY = 1'b1
  } bus_state_e;

  localparam int I2C_SYNC_STAGES = 2;
  localparam int I2C_FILT_LEN    = 4;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/i2c_line_cond_glitch_filter.sv
// Per-line conditioner: SYNC_STAGES-flop synchroniser followed by a
// persistence filter. The filtered level only changes after the synced level
// has disagreed with it for FILT_LEN consecutive cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   pin_i      : raw asynchronous pin
//   lvl_o      : filtered level (registered, resets to 1 = idle bus)
//   tog_o      : lvl_o changes on the next clock edge (combinational)
//   glitch_o   : a partially-counted disagreement just ended without acceptance
module i2c_line_cond_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic lvl_o,
  output logic tog_o,
  output logic glitch_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   filt_q;
  logic [7:0]             cnt_q;
  logic [7:0]             cnt_d;
  logic                   mismatch;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign mismatch = (synced != filt_q);
  // Mismatch has persisted long enough: accept the new level on this edge.
  assign tog_o    = mismatch && (cnt_q == 8'(FILT_LEN - 1));
  assign glitch_o = !mismatch && (cnt_q != 8'd0);
  assign lvl_o    = filt_q;

  always_comb begin
    cnt_d = 8'd0;
    if (mismatch && !tog_o) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      filt_q <= 1'b1;
      cnt_q  <= 8'd0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      cnt_q  <= cnt_d;
      if (tog_o) filt_q <= ~filt_q;
    end
  end

endmodule

// File: rtl/i2c_line_cond.sv
// I2C slave input conditioner: synchronises and deglitches SCL/SDA, then
// derives one-cycle SCL edge, START and STOP strobes and a bus-busy flag.
// Optional feature macro: I2C_COND_GLITCH_CNT_EN adds the glitch_cnt port.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   scl_in, sda_in     : raw asynchronous pins
//   scl, sda           : filtered levels
//   scl_rise, scl_fall : 1-cycle filtered SCL edge strobes
//   start_det/stop_det : 1-cycle START (incl. repeated) / STOP strobes
//   bus_busy           : bus state register (1 = BUSY), START..STOP
//   glitch_cnt         : saturating count of rejected pulses (macro only)
module i2c_line_cond
  import i2c_line_cond_pkg::*;
#(
  parameter int SYNC_STAGES = I2C_SYNC_STAGES,
  parameter int FILT_LEN    = I2C_FILT_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl,
  output logic       sda,
  output logic       scl_rise,
  output logic       scl_fall,
  output logic       start_det,
  output logic       stop_det,
  output logic       bus_busy
`ifdef I2C_COND_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  logic scl_lvl, scl_tog, scl_gl;
  logic sda_lvl, sda_tog, sda_gl;

  i2c_line_cond_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .rst_n(rst_n), .pin_i(scl_in),
    .lvl_o(scl_lvl), .tog_o(scl_tog), .glitch_o(scl_gl)
  );

  i2c_line_cond_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .rst_n(rst_n), .pin_i(sda_in),
    .lvl_o(sda_lvl), .tog_o(sda_tog), .glitch_o(sda_gl)
  );

  bus_state_e state_q;
  logic       scl_rise_q, scl_fall_q, start_q, stop_q;

  assign scl       = scl_lvl;
  assign sda       = sda_lvl;
  assign scl_rise  = scl_rise_q;
  assign scl_fall  = scl_fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign bus_busy  = (state_q == I2C_BUS_BUSY);

  // Strobes are computed from the filters' pending toggles so they appear in
  // the same cycle as the new filtered level. START/STOP need SCL high now and
  // in the previous cycle, i.e. SCL is high and not toggling on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= I2C_BUS_IDLE;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_rise_q <= scl_tog & ~scl_lvl;
      scl_fall_q <= scl_tog &  scl_lvl;
      start_q    <= sda_tog &  sda_lvl & ~scl_tog & scl_lvl;
      stop_q     <= sda_tog & ~sda_lvl & ~scl_tog & scl_lvl;
      case (state_q)
        I2C_BUS_IDLE: if (start_q) state_q <= I2C_BUS_BUSY;
        I2C_BUS_BUSY: if (stop_q)  state_q <= I2C_BUS_IDLE;
        default:                   state_q <= I2C_BUS_IDLE;
      endcase
    end
  end

`ifdef I2C_COND_GLITCH_CNT_EN
  logic [7:0] glitch_cnt_q;
  assign glitch_cnt = glitch_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) glitch_cnt_q <= 8'd0;
    else        glitch_cnt_q <= sat_add8(glitch_cnt_q, {1'b0, scl_gl} + {1'b0, sda_gl});
  end
`else
  logic unused_glitch;
  assign unused_glitch = scl_gl ^ sda_gl;
`endif

endmodule

// File: tb/tb_i2c_line_cond.sv
module tb_i2c_line_cond;
  import i2c_line_cond_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_in = 1'b1;
  logic sda_in = 1'b1;
  always #5 clk = ~clk;

  logic       scl, sda, scl_rise, scl_fall, start_det, stop_det, bus_busy;
`ifdef I2C_COND_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  i2c_line_cond dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
    .scl(scl), .sda(sda), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .stop_det(stop_det), .bus_busy(bus_busy)
`ifdef I2C_COND_GLITCH_CNT_EN
    , .glitch_cnt(glitch_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // pulse tallies gathered while stepping the clock
  int rise_n, fall_n, start_n, stop_n, both_n, busy_drop_n;
  bit watch_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_tallies();
    rise_n = 0; fall_n = 0; start_n = 0; stop_n = 0; both_n = 0; busy_drop_n = 0;
  endtask

  // advance n clocks, sampling 1 time unit after each rising edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rise_n  += int'(scl_rise);
      fall_n  += int'(scl_fall);
      start_n += int'(start_det);
      stop_n  += int'(stop_det);
      if (start_det && stop_det) both_n++;
      if (watch_busy && !bus_busy) busy_drop_n++;
    end
  endtask

  initial begin
    clear_tallies();

    // 1. reset with idle pins
    tick(3);
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    check("rst_pulses", {scl_rise, scl_fall, start_det, stop_det}, 0);
    check("rst_busy", bus_busy, 0);
`ifdef I2C_COND_GLITCH_CNT_EN
    check("rst_glitch", glitch_cnt, 0);
`endif
    rst_n = 1'b1;
    tick(3);
    check("idle_busy", bus_busy, 0);

    // 2. START latency (2 sync + 4 filter) and STOP
    clear_tallies();
    sda_in = 1'b0;
    tick(5);
    check("start_sda_early", sda, 1);
    check("start_none_early", start_n, 0);
    tick(1);
    check("start_sda_fell", sda, 0);
    check("start_pulse", start_det, 1);
    check("start_busy_lag", bus_busy, 0);
    tick(1);
    check("start_pulse_end", start_det, 0);
    check("start_busy", bus_busy, 1);
    tick(8);
    sda_in = 1'b1;
    tick(5);
    check("stop_none_early", stop_n, 0);
    tick(1);
    check("stop_pulse", stop_det, 1);
    check("stop_busy_lag", bus_busy, 1);
    tick(1);
    check("stop_busy", bus_busy, 0);
    check("stop_start_cnt", start_n, 1);

    // 3. 3-cycle SCL low pulse is rejected
    clear_tallies();
    scl_in = 1'b0;
    tick(3);
    scl_in = 1'b1;
    tick(4);
    check("glitch_scl_mid", scl, 1);
    tick(8);
    check("glitch_scl", scl, 1);
    check("glitch_edges", rise_n + fall_n, 0);
`ifdef I2C_COND_GLITCH_CNT_EN
    check("glitch_cnt1", glitch_cnt, 1);
`endif

    // 4. START, 9 SCL clocks, repeated START
    sda_in = 1'b0;
    tick(10);
    check("rs_busy0", bus_busy, 1);
    clear_tallies();
    watch_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      scl_in = 1'b0;
      tick(4);
      if (i == 8) sda_in = 1'b1;
      tick(4);
      scl_in = 1'b1;
      tick(8);
    end
    sda_in = 1'b0;
    tick(10);
    check("rs_rise", rise_n, 9);
    check("rs_fall", fall_n, 9);
    check("rs_start", start_n, 1);
    check("rs_stop", stop_n, 0);
    check("rs_busy_drop", busy_drop_n, 0);
    check("rs_busy", bus_busy, 1);
    watch_busy = 1'b0;

    // 5. STOP, then SCL and SDA fall together: edge only, no START
    sda_in = 1'b1;
    tick(10);
    check("sim_stop_busy", bus_busy, 0);
    clear_tallies();
    scl_in = 1'b0;
    sda_in = 1'b0;
    tick(10);
    check("sim_fall", fall_n, 1);
    check("sim_start", start_n, 0);
    check("sim_busy", bus_busy, 0);
    scl_in = 1'b1;
    sda_in = 1'b1;
    tick(10);
    check("sim_rise", rise_n, 1);
    check("sim_stop", stop_n, 0);

    // 6. reset mid-byte, then normal START, then glitch saturation
    sda_in = 1'b0;
    tick(10);
    for (int i = 0; i < 3; i++) begin
      scl_in = 1'b0;
      tick(8);
      scl_in = 1'b1;
      tick(8);
    end
    scl_in = 1'b0;
    tick(8);
    check("mid_scl_low", scl, 0);
    check("mid_busy", bus_busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus_busy, 0);
    check("mid_rst_scl", scl, 1);
    check("mid_rst_sda", sda, 1);
    scl_in = 1'b1;
    sda_in = 1'b1;
    tick(3);
    rst_n = 1'b1;
    clear_tallies();
    tick(12);
    check("post_rst_pulses", rise_n + fall_n + start_n + stop_n, 0);
    check("post_rst_busy", bus_busy, 0);
    sda_in = 1'b0;
    tick(10);
    check("post_rst_start", start_n, 1);
    check("post_rst_busy1", bus_busy, 1);

    clear_tallies();
    for (int i = 0; i < 300; i++) begin
      scl_in = 1'b0;
      tick(2);
      scl_in = 1'b1;
      tick(6);
    end
    check("sat_edges", rise_n + fall_n, 0);
    check("sat_busy", bus_busy, 1);
`ifdef I2C_COND_GLITCH_CNT_EN
    check("sat_glitch", glitch_cnt, 8'hFF);
`endif
    check("never_both", both_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
